// File: rtl/accum_table.sv
// accum_table: counter table for the accumulate side of search_and_add.
//
// Accumulate requests (accum_addr/accum_din/accum_we) are added into a
// block-RAM array by read-modify-write. The most recent RAM write is
// forwarded into the add stage, so back-to-back increments to one index are
// never lost. On dump_kick the whole table is streamed out under
// dump_valid/dump_ready, optionally zeroing each entry as it is taken.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   ready                        table cleared, accumulates accepted
//   accum_addr/accum_din/accum_we   accumulate request stream
//   dump_kick, dump_clear        start a dump, zero-on-read select
//   dump_busy                    drain or dump in progress
//   dump_addr/dump_dout/dump_valid/dump_ready   dump stream
//   err                          sticky request-drop flag
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | writing zero to every index, one per cycle
// ST_IDLE  | accepting accumulates, waiting for dump_kick
// ST_DRAIN | two cycles letting in-flight accumulates commit
// ST_DUMP  | streaming indices 0..DEPTH-1 to the reader
module accum_table #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  ready,
    input  logic [31:0]           accum_addr,
    input  logic [DATA_WIDTH-1:0] accum_din,
    input  logic                  accum_we,
    input  logic                  dump_kick,
    input  logic                  dump_clear,
    output logic                  dump_busy,
    output logic [ADDR_WIDTH-1:0] dump_addr,
    output logic [DATA_WIDTH-1:0] dump_dout,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic                  err
);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_DRAIN, ST_DUMP} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;
    logic                  drain_cnt_q, drain_cnt_d;
    logic                  dump_clr_q, dump_clr_d;
    logic [ADDR_WIDTH-1:0] dump_addr_q, dump_addr_d;
    logic                  dump_valid_q, dump_valid_d;
    logic                  err_q, err_d;

    // p0: request captured, RAM read issued; p1: read data back, add and write
    logic                  p0_valid_q, p0_valid_d;
    logic [ADDR_WIDTH-1:0] p0_addr_q, p0_addr_d;
    logic [DATA_WIDTH-1:0] p0_din_q, p0_din_d;
    logic                  p1_valid_q, p1_valid_d;
    logic [ADDR_WIDTH-1:0] p1_addr_q, p1_addr_d;
    logic [DATA_WIDTH-1:0] p1_din_q, p1_din_d;

    // copy of the last RAM write; the RAM returns old data when a read and a
    // write to the same index share an edge, so this copy covers that case
    logic                  wb_valid_q, wb_valid_d;
    logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr, ram_raddr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  addr_ok, accept, drop, hs;
    logic [DATA_WIDTH-1:0] old_val, sum;

    assign addr_ok    = (accum_addr[31:ADDR_WIDTH] == '0);
    assign ready      = (state_q != ST_CLEAR);
    assign dump_busy  = (state_q == ST_DRAIN) || (state_q == ST_DUMP);
    assign accept     = accum_we && addr_ok && (state_q == ST_IDLE);
    assign drop       = accum_we && !accept;
    assign hs         = (state_q == ST_DUMP) && dump_valid_q && dump_ready;
    assign old_val    = (wb_valid_q && (wb_addr_q == p1_addr_q)) ? wb_data_q : rdata_q;
    assign sum        = old_val + p1_din_q;

    assign dump_addr  = dump_addr_q;
    assign dump_valid = dump_valid_q;
    assign dump_dout  = dump_valid_q ? rdata_q : '0;
    assign err        = err_q;

    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        drain_cnt_d  = drain_cnt_q;
        dump_clr_d   = dump_clr_q;
        dump_addr_d  = dump_addr_q;
        dump_valid_d = dump_valid_q;
        err_d        = err_q | drop;
        p0_valid_d   = accept;
        p0_addr_d    = accum_addr[ADDR_WIDTH-1:0];
        p0_din_d     = accum_din;
        p1_valid_d   = p0_valid_q;
        p1_addr_d    = p0_addr_q;
        p1_din_d     = p0_din_q;
        ram_we       = 1'b0;
        ram_waddr    = p1_addr_q;
        ram_wdata    = sum;
        ram_raddr    = p0_addr_q;
        case (state_q)
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_idx_q;
                ram_wdata = '0;
                clr_idx_d = clr_idx_q + ADDR_WIDTH'(1);
                if (clr_idx_q == LAST_IDX) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                ram_we = p1_valid_q;
                if (dump_kick) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = 1'b1;
                    dump_clr_d  = dump_clear;
                    dump_addr_d = '0;
                end
            end
            ST_DRAIN: begin
                ram_we      = p1_valid_q;
                drain_cnt_d = drain_cnt_q - 1'b1;
                if (drain_cnt_q == 1'b0) state_d = ST_DUMP;
            end
            ST_DUMP: begin
                // prefetch the next word on a handshake, else re-read the held one
                ram_raddr    = hs ? dump_addr_q + ADDR_WIDTH'(1) : dump_addr_q;
                ram_we       = hs && dump_clr_q;
                ram_waddr    = dump_addr_q;
                ram_wdata    = '0;
                dump_valid_d = 1'b1;
                if (hs) begin
                    dump_addr_d = dump_addr_q + ADDR_WIDTH'(1);
                    if (dump_addr_q == LAST_IDX) begin
                        dump_valid_d = 1'b0;
                        state_d      = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase
        wb_valid_d = ram_we;
        wb_addr_d  = ram_waddr;
        wb_data_d  = ram_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_CLEAR;
            clr_idx_q    <= '0;
            drain_cnt_q  <= 1'b0;
            dump_clr_q   <= 1'b0;
            dump_addr_q  <= '0;
            dump_valid_q <= 1'b0;
            err_q        <= 1'b0;
            p0_valid_q   <= 1'b0;
            p0_addr_q    <= '0;
            p0_din_q     <= '0;
            p1_valid_q   <= 1'b0;
            p1_addr_q    <= '0;
            p1_din_q     <= '0;
            wb_valid_q   <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            drain_cnt_q  <= drain_cnt_d;
            dump_clr_q   <= dump_clr_d;
            dump_addr_q  <= dump_addr_d;
            dump_valid_q <= dump_valid_d;
            err_q        <= err_d;
            p0_valid_q   <= p0_valid_d;
            p0_addr_q    <= p0_addr_d;
            p0_din_q     <= p0_din_d;
            p1_valid_q   <= p1_valid_d;
            p1_addr_q    <= p1_addr_d;
            p1_din_q     <= p1_din_d;
            wb_valid_q   <= wb_valid_d;
            wb_addr_q    <= wb_addr_d;
            wb_data_q    <= wb_data_d;
        end
    end

    // block RAM: no reset, read-before-write
    always_ff @(posedge clk) begin
        if (ram_we && !reset) mem_q[ram_waddr] <= ram_wdata;
        rdata_q <= mem_q[ram_raddr];
    end
endmodule

// File: tb/tb_accum_table.sv
module tb_accum_table;
    localparam int AW = 4;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          ready;
    logic [31:0]   accum_addr;
    logic [DW-1:0] accum_din;
    logic          accum_we;
    logic          dump_kick;
    logic          dump_clear;
    logic          dump_busy;
    logic [AW-1:0] dump_addr;
    logic [DW-1:0] dump_dout;
    logic          dump_valid;
    logic          dump_ready;
    logic          err;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] exp_mem [16];

    always #5 clk = ~clk;

    accum_table #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .ready      (ready),
        .accum_addr (accum_addr),
        .accum_din  (accum_din),
        .accum_we   (accum_we),
        .dump_kick  (dump_kick),
        .dump_clear (dump_clear),
        .dump_busy  (dump_busy),
        .dump_addr  (dump_addr),
        .dump_dout  (dump_dout),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .err        (err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    endtask

    // current cycle must be the first (or n_low-th from last) with ready low
    task automatic wait_clear(input string tag, input int n_low);
        for (int i = 0; i < n_low; i++) begin
            n_checks++;
            if (ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_ready_low cycle %0d: got %b want 0", tag, i, ready);
            end
            step();
        end
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready_rise: got %b want 1", tag, ready);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks++;
        if ({ready, dump_busy, dump_valid, err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL %s_flags: ready/busy/valid/err got %b want 0000", tag,
                     {ready, dump_busy, dump_valid, err});
        end
        n_checks++;
        if (dump_addr !== '0 || dump_dout !== '0) begin
            n_fail++;
            $display("FAIL %s_dump_word: addr %0d dout %h want 0/0", tag, dump_addr, dump_dout);
        end
    endtask

    // kick at the current cycle; inject drives a dropped accumulate during DRAIN
    task automatic run_dump(input string tag, input logic clr, input logic toggle,
                            input logic inject);
        int   idx;
        int   budget;
        logic phase;
        dump_kick  = 1'b1;
        dump_clear = clr;
        dump_ready = 1'b1;
        step();
        dump_kick  = 1'b0;
        dump_clear = 1'b0;
        accum_we   = inject;
        accum_addr = 32'd2;
        accum_din  = 64'd100;
        n_checks++;
        if (dump_busy !== 1'b1 || dump_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_kick_plus1: busy %b valid %b want 1 0", tag, dump_busy, dump_valid);
        end
        step();
        accum_we = 1'b0;
        step();
        n_checks++;
        if (dump_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_kick_plus3: valid %b want 0", tag, dump_valid);
        end
        step();
        idx    = 0;
        budget = 0;
        phase  = 1'b1;
        while (idx < 16 && budget < 64) begin
            dump_ready = toggle ? phase : 1'b1;
            n_checks++;
            if (dump_valid !== 1'b1 || dump_addr !== AW'(idx) || dump_dout !== exp_mem[idx]) begin
                n_fail++;
                $display("FAIL %s_word%0d: valid %b addr %0d dout %h want 1 %0d %h",
                         tag, idx, dump_valid, dump_addr, dump_dout, idx, exp_mem[idx]);
            end
            if (dump_ready) idx++;
            phase = ~phase;
            step();
            budget++;
        end
        dump_ready = 1'b1;
        n_checks++;
        if (idx < 16) begin
            n_fail++;
            $display("FAIL %s_budget: words %0d want 16", tag, idx);
        end
        n_checks++;
        if (dump_busy !== 1'b0 || dump_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_end: busy %b valid %b want 0 0", tag, dump_busy, dump_valid);
        end
        if (clr) clear_model();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (10) step();
        check_reset_outputs("reset");
        reset = 1'b0;
        wait_clear("reset", 16);
        clear_model();
        run_dump("reset_dump", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        accum_we   = 1'b1;
        accum_addr = 32'd5;
        accum_din  = 64'd1;
        step();
        accum_din  = 64'd2;
        step();
        accum_din  = 64'd3;
        step();
        accum_we   = 1'b0;
        exp_mem[5] = 64'd6;
        run_dump("b2b", 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_err: got %b want 0", err);
        end
    endtask

    // wrap at 2**64, then an accumulate issued in the kick cycle itself
    task automatic test_wrap_and_kick();
        accum_we   = 1'b1;
        accum_addr = 32'd3;
        accum_din  = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        accum_din  = 64'd2;
        step();
        accum_addr = 32'd9;
        accum_din  = 64'h55;
        exp_mem[3] = 64'd1;
        exp_mem[9] = 64'h55;
        run_dump("wrap", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_drop();
        accum_we   = 1'b1;
        accum_addr = 32'h10;
        accum_din  = 64'd7;
        step();
        accum_we   = 1'b0;
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_addr_err: got %b want 1", err);
        end
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_err_reset: got %b want 0", err);
        end
        reset      = 1'b0;
        accum_we   = 1'b1;
        accum_addr = 32'd1;
        accum_din  = 64'd5;
        step();
        step();
        step();
        accum_we   = 1'b0;
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_clear_err: got %b want 1", err);
        end
        wait_clear("drop", 13);
        accum_we   = 1'b1;
        accum_addr = 32'h10;
        accum_din  = 64'd7;
        step();
        accum_addr = 32'h8000_0003;
        accum_din  = 64'd9;
        step();
        accum_we   = 1'b0;
        clear_model();
        run_dump("drop_dump", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_dump_clear();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        wait_clear("dclr", 16);
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL dclr_err_start: got %b want 0", err);
        end
        accum_we   = 1'b1;
        accum_addr = 32'd2;
        accum_din  = 64'd4;
        step();
        accum_din  = 64'd5;
        step();
        accum_addr = 32'd15;
        accum_din  = 64'd4;
        step();
        accum_we   = 1'b0;
        clear_model();
        exp_mem[2]  = 64'd9;
        exp_mem[15] = 64'd4;
        run_dump("dclr_first", 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL dclr_busy_drop_err: got %b want 1", err);
        end
        run_dump("dclr_second", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_dump();
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_clear("mid", 16);
        accum_we   = 1'b1;
        accum_addr = 32'd4;
        accum_din  = 64'h33;
        step();
        accum_we   = 1'b0;
        dump_kick  = 1'b1;
        dump_ready = 1'b1;
        step();
        dump_kick  = 1'b0;
        repeat (3) step();
        repeat (7) step();
        n_checks++;
        if (dump_valid !== 1'b1 || dump_addr !== 4'd7 || dump_dout !== 64'd0) begin
            n_fail++;
            $display("FAIL mid_word7: valid %b addr %0d dout %h want 1 7 0",
                     dump_valid, dump_addr, dump_dout);
        end
        reset = 1'b1;
        step();
        check_reset_outputs("mid_reset");
        reset = 1'b0;
        wait_clear("mid_rel", 16);
        clear_model();
        run_dump("mid_dump", 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        accum_addr = '0;
        accum_din  = '0;
        accum_we   = 1'b0;
        dump_kick  = 1'b0;
        dump_clear = 1'b0;
        dump_ready = 1'b1;
        clear_model();
        test_reset();
        test_back_to_back();
        test_wrap_and_kick();
        test_drop();
        test_dump_clear();
        test_reset_mid_dump();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/accum_table.md
# accum_table

Counter table on the accumulate side of `search_and_add`. It receives the `accum_addr`/`accum_din`/`accum_we` write stream, adds each increment into a block-RAM array with read-modify-write, and forwards results between back-to-back writes. On request it streams the whole table out to the host-side reader under valid/ready flow control, optionally clearing each entry as it is read.

## Interface

- `ADDR_WIDTH`, default 10: table index width; `DEPTH` = 2**ADDR_WIDTH entries.
- `DATA_WIDTH`, default 64: count width; must equal the `accum_din` width.
- `clk` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `ready` out 1: table cleared and accepting accumulates.
- `accum_addr` in 32: entry index; only the low ADDR_WIDTH bits are used.
- `accum_din` in DATA_WIDTH: increment to add.
- `accum_we` in 1: one accumulate request per cycle; there is no backpressure.
- `dump_kick` in 1: start a full-table dump (single-cycle pulse).
- `dump_clear` in 1: sampled with `dump_kick`; when 1, each entry is zeroed after it is read.
- `dump_busy` out 1: dump in progress.
- `dump_addr` out ADDR_WIDTH: index of the current dump word.
- `dump_dout` out DATA_WIDTH: count of the current dump word.
- `dump_valid` out 1: dump word present.
- `dump_ready` in 1: downstream accepts the dump word.
- `err` out 1: sticky request-drop flag; cleared only by `reset`.

## Operation

- States: CLEAR, IDLE, DRAIN, DUMP.
- CLEAR
  - Entered on any cycle with `reset`=1. Writes zero to index 0..DEPTH-1, one per cycle, starting on the first cycle with `reset`=0.
  - Goes to IDLE after index DEPTH-1 is written.
- IDLE
  - An accumulate request enters a 3-stage pipeline: S0 captures addr/din; S1 reads memory (synchronous read, 1 cycle); S2 computes sum = old + din modulo 2**DATA_WIDTH and writes it back.
  - Forwarding: if S1's address matches a write in S2 or the one just committed, the forwarded value replaces the RAM value. Back-to-back increments to one address must never be lost.
- Request drops (request discarded, `err`<=1):
  - `accum_we`=1 with any of `accum_addr[31:ADDR_WIDTH]` nonzero.
  - `accum_we`=1 while `ready`=0.
  - `accum_we`=1 while `dump_busy`=1.
- `dump_kick`
  - Honoured only in IDLE with `ready`=1. Otherwise ignored, with no error.
  - On kick: IDLE to DRAIN for 2 cycles (in-flight writes commit), then DUMP.
- DUMP
  - Reads indices 0..DEPTH-1 in order and presents each word on `dump_addr`/`dump_dout` with `dump_valid`=1.
  - The word holds stable until the cycle `dump_valid`=1 and `dump_ready`=1.
  - If `dump_clear` was latched, the entry is written to zero on its handshake cycle.
  - After the handshake of index DEPTH-1, returns to IDLE.
- `accum_we` together with `dump_kick` in IDLE: the accumulate is accepted and committed before the first dump read (it is covered by DRAIN).

## Timing

- Reset values:
  - `ready`=0, `dump_busy`=0, `dump_valid`=0, `dump_addr`=0, `dump_dout`=0, `err`=0.
  - State=CLEAR; pipeline valid bits cleared.
- Clear duration: `ready` rises exactly DEPTH cycles after the first cycle with `reset`=0.
- Accumulate latency: request at cycle N; RAM written at the end of N+2. A dump started at kick cycle N+1 or later includes it.
- Throughput: 1 accumulate per cycle, sustained, including the same address every cycle.
- Dump:
  - `dump_kick` at cycle K: `dump_busy`=1 at K+1 and first `dump_valid`=1 at K+4.
  - With `dump_ready` held at 1, one word per cycle (read of index i+1 is prefetched during word i).
  - `dump_busy` and `dump_valid` fall the cycle after the final handshake. `dump_busy` covers DRAIN and DUMP.
- `reset` mid-dump or mid-clear: on the next edge all outputs take their reset values, the dump is aborted without completing, and CLEAR restarts from index 0.

## Test plan

Parameters: ADDR_WIDTH=4 (DEPTH=16), DATA_WIDTH=64.

- Reset 10 cycles, then release -> `ready`=0 for exactly 16 cycles, then 1; dump returns 16 words, all 0, `dump_addr` 0..15 in order.
- `accum_we` on 3 consecutive cycles, addr 5, din 1, 2, 3; `dump_kick` on the next cycle -> entry 5 = 6, all others 0, `err`=0.
- addr 3: din 0xFFFF_FFFF_FFFF_FFFF, then din 2 a cycle later -> entry 3 = 1 (wrap).
- addr 0x10 din 7; also `accum_we` during CLEAR -> both dropped, `err`=1, table all zero.
- Dump with `dump_clear`=1 and `dump_ready` toggling 1,0,1,0 after entries 2 = 9 and 15 = 4 -> 16 words in order, each stable while stalled, values 9 and 4 at indices 2 and 15; a second dump is all zero.
- `reset` asserted mid-dump at index 7 -> `dump_busy`=0 and `ready`=0 next cycle; `ready`=1 16 cycles after release; contents all zero.
